// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule generator.
// Holds the small-sigma rotate/shift amounts and the LOAD/EXPAND state encoding.
package sha256_pkg;

  localparam int ROUNDS     = 64;
  localparam int WORD_W     = 32;
  localparam int IDX_W      = 6;
  localparam int LOAD_WORDS = 16;

  localparam int unsigned SIG0_R1 = 7;
  localparam int unsigned SIG0_R2 = 18;
  localparam int unsigned SIG0_SH = 3;
  localparam int unsigned SIG1_R1 = 17;
  localparam int unsigned SIG1_R2 = 19;
  localparam int unsigned SIG1_SH = 10;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic {
    LOAD,
    EXPAND
  } state_e;

  // Rotate right; amounts are always compile-time constants in 1..31.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the message producer, the schedule generator
// and the round datapath that consumes W_t.
interface sha256_msg_sched_if;
  import sha256_pkg::*;

  word_t in_word;
  logic  in_valid;
  logic  in_ready;
  word_t w_word;
  idx_t  w_idx;
  logic  w_last;
  logic  w_valid;
  logic  w_ready;
  logic  busy;

  modport master (
    output in_word, in_valid, w_ready,
    input  in_ready, w_word, w_idx, w_last, w_valid, busy
  );

  modport slave (
    input  in_word, in_valid, w_ready,
    output in_ready, w_word, w_idx, w_last, w_valid, busy
  );

endinterface

// File: rtl/sha256_small_sigma.sv
// Lower-case sigma of the message schedule: two rotates XORed with a logical
// right shift. Not the capital Sigma used by the compression rounds.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int unsigned ROT_A = 7,
  parameter int unsigned ROT_B = 18,
  parameter int unsigned SHR   = 3
) (
  input  word_t x,
  output word_t y
);

  assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// Streaming SHA-256 message schedule: passes the 16 block words through, then
// expands W16..W63 from a 16-word sliding window, one word per output slot.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS = sha256_pkg::ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
  sha256_msg_sched_if.slave  bus
);

  localparam idx_t LAST_IDX  = idx_t'(ROUNDS - 1);
  localparam idx_t LAST_LOAD = idx_t'(LOAD_WORDS - 1);

  state_e state;
  state_e state_nxt;
  idx_t   t;
  word_t  win [LOAD_WORDS];

  word_t  slot_word;
  idx_t   slot_idx;
  logic   slot_valid;
  logic   busy_q;

  logic   adv;
  logic   in_ready_c;
  logic   load_in;
  logic   load_exp;
  logic   step;
  logic   w63_acc;

  word_t  sig0;
  word_t  sig1;
  word_t  sum_a;
  word_t  sum_b;
  word_t  w_exp;
  word_t  new_word;

  sha256_small_sigma #(
    .ROT_A (SIG0_R1),
    .ROT_B (SIG0_R2),
    .SHR   (SIG0_SH)
  ) u_sig0 (
    .x (win[1]),
    .y (sig0)
  );

  sha256_small_sigma #(
    .ROT_A (SIG1_R1),
    .ROT_B (SIG1_R2),
    .SHR   (SIG1_SH)
  ) u_sig1 (
    .x (win[14]),
    .y (sig1)
  );

  // Two balanced adder levels keep the sigma outputs off a 4-deep carry chain.
  assign sum_a = sig1 + win[9];
  assign sum_b = sig0 + win[0];
  assign w_exp = sum_a + sum_b;

  assign adv      = !slot_valid || bus.w_ready;
  assign step     = load_in || load_exp;
  assign new_word = load_in ? bus.in_word : w_exp;
  assign w63_acc  = slot_valid && bus.w_ready && (slot_idx == LAST_IDX);

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    load_in    = 1'b0;
    load_exp   = 1'b0;
    case (state)
      LOAD: begin
        in_ready_c = adv;
        load_in    = bus.in_valid && adv;
        if (load_in && (t == LAST_LOAD)) begin
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        load_exp = adv;
        if (adv && (t == LAST_IDX)) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Window and counter only move when the output slot can take a new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      for (int i = 0; i < LOAD_WORDS; i++) begin
        win[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < LOAD_WORDS - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[LOAD_WORDS-1] <= new_word;
      t <= (t == LAST_IDX) ? '0 : t + idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_word  <= '0;
      slot_idx   <= '0;
      slot_valid <= 1'b0;
    end else if (step) begin
      slot_word  <= new_word;
      slot_idx   <= t;
      slot_valid <= 1'b1;
    end else if (bus.w_ready) begin
      slot_valid <= 1'b0;
    end
  end

  // A word-0 accept in the same cycle as W63 leaves busy asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (load_in) begin
      busy_q <= 1'b1;
    end else if (w63_acc) begin
      busy_q <= 1'b0;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.w_word   = slot_word;
  assign bus.w_idx    = slot_idx;
  assign bus.w_valid  = slot_valid;
  assign bus.w_last   = slot_valid && (slot_idx == LAST_IDX);
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized bench for sha256_msg_sched against a textbook SHA-256 schedule
// model plus a cycle-level handshake model of the valid/ready behaviour.
module tb_sha256_msg_sched;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();

  sha256_msg_sched #(
    .ROUNDS (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          nVectors = 0;
  int          nMiscompares = 0;
  logic [31:0] inQ[$];
  exp_t        expQ[$];
  logic [31:0] outLog[$];
  bit          monOn = 1'b0;
  bit          mValid = 1'b0;
  bit          mBusy = 1'b0;
  int          mGen = 0;
  bit          lastInFire = 1'b0;
  int          validPct = 100;
  int          readyPct = 100;
  longint      cyc = 0;
  longint      firstFireCyc = 0;
  longint      lastFireCyc = 0;
  int          sameCycCnt = 0;
  bit          advM, expM, inFireM, outFireM, loadedM;
  exp_t        cur;
  logic [31:0] popWord;
  logic [31:0] abcBlock [16];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] smallS0(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallS1(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
  endfunction

  // Queue one block for the driver and its full 64-word schedule for the checker.
  task automatic applyStimulus(input logic [31:0] m [16]);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      w[i] = smallS1(w[i-2]) + w[i-7] + smallS0(w[i-15]) + w[i-16];
    end
    for (int i = 0; i < 16; i++) inQ.push_back(m[i]);
    for (int i = 0; i < 64; i++) begin
      e.w   = w[i];
      e.idx = 6'(i);
      expQ.push_back(e);
    end
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int n;
    n = 0;
    while ((inQ.size() > 0 || expQ.size() > 0 || mValid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic randomBlock(output logic [31:0] m [16]);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(7) == 0) m[i] = 32'hFFFF_FFFF;
      else if ($urandom_range(1) == 0) m[i] = $urandom | 32'h8000_0000;
      else m[i] = $urandom;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.w_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!(bus.in_valid && !lastInFire && inQ.size() > 0)) begin
        if (inQ.size() > 0 && ($urandom_range(99) < validPct)) begin
          bus.in_valid = 1'b1;
          bus.in_word  = inQ[0];
        end else begin
          bus.in_valid = 1'b0;
          bus.in_word  = $urandom;
        end
      end
      bus.w_ready = ($urandom_range(99) < readyPct);
    end
  end

  // Handshake model: checks outputs each cycle, then advances to the next edge.
  always @(negedge clk) begin
    cyc++;
    if (!monOn) begin
      lastInFire = 1'b0;
    end else begin
      advM     = !mValid || bus.w_ready;
      expM     = (mGen >= 16);
      inFireM  = !rst && bus.in_valid && !expM && advM;
      outFireM = mValid && bus.w_ready;
      checkOutput("w_valid", 32'(bus.w_valid), 32'(mValid));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(!expM && advM));
      checkOutput("busy", 32'(bus.busy), 32'(mBusy));
      if (mValid) begin
        if (expQ.size() == 0) begin
          checkOutput("exp_underflow", 32'(bus.w_valid), 32'd0);
        end else begin
          cur = expQ[0];
          checkOutput("w_word", bus.w_word, cur.w);
          checkOutput("w_idx", 32'(bus.w_idx), 32'(cur.idx));
          checkOutput("w_last", 32'(bus.w_last), 32'(cur.idx == 6'd63));
          if (outFireM) begin
            cur = expQ.pop_front();
            if (outLog.size() == 0) firstFireCyc = cyc;
            lastFireCyc = cyc;
            outLog.push_back(bus.w_word);
            if (cur.idx == 6'd63 && inFireM) sameCycCnt++;
          end
        end
      end else begin
        checkOutput("w_last_idle", 32'(bus.w_last), 32'd0);
      end
      if (inFireM) popWord = inQ.pop_front();
      lastInFire = inFireM;
      loadedM = inFireM || (expM && advM);
      if (rst) begin
        mValid = 1'b0;
        mGen   = 0;
        mBusy  = 1'b0;
        inQ.delete();
        expQ.delete();
        lastInFire = 1'b0;
      end else begin
        if (loadedM) begin
          mValid = 1'b1;
          mGen   = (mGen == 63) ? 0 : mGen + 1;
        end else if (bus.w_ready) begin
          mValid = 1'b0;
        end
        if (inFireM) mBusy = 1'b1;
        else if (outFireM && cur.idx == 6'd63) mBusy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] blk [16];
    int n;

    for (int i = 0; i < 16; i++) abcBlock[i] = 32'h0;
    abcBlock[0]  = 32'h6162_6380;
    abcBlock[15] = 32'h0000_0018;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_w_valid", 32'(bus.w_valid), 32'd0);
    checkOutput("rst_w_word", bus.w_word, 32'd0);
    checkOutput("rst_w_idx", 32'(bus.w_idx), 32'd0);
    checkOutput("rst_w_last", 32'(bus.w_last), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 monOn = 1'b1;

    $display("[TB] abc block, no back-pressure");
    outLog.delete();
    applyStimulus(abcBlock);
    waitDrain(300, "abc");
    checkOutput("abc_count", 32'(outLog.size()), 32'd64);
    if (outLog.size() == 64) begin
      checkOutput("abc_w16", outLog[16], 32'h6162_6380);
      checkOutput("abc_w17", outLog[17], 32'h000F_0000);
    end
    @(negedge clk);
    checkOutput("abc_busy_after", 32'(bus.busy), 32'd0);

    $display("[TB] abc block, 50%% back-pressure");
    readyPct = 50;
    outLog.delete();
    applyStimulus(abcBlock);
    waitDrain(2000, "bp");
    checkOutput("bp_count", 32'(outLog.size()), 32'd64);
    if (outLog.size() == 64) checkOutput("bp_w17", outLog[17], 32'h000F_0000);
    readyPct = 100;

    $display("[TB] two blocks back-to-back");
    outLog.delete();
    sameCycCnt = 0;
    randomBlock(blk);
    applyStimulus(blk);
    randomBlock(blk);
    applyStimulus(blk);
    waitDrain(500, "b2b");
    checkOutput("b2b_count", 32'(outLog.size()), 32'd128);
    checkOutput("b2b_span", 32'(lastFireCyc - firstFireCyc), 32'd127);
    checkOutput("b2b_same_cycle", 32'(sameCycCnt), 32'd1);

    $display("[TB] reset in the middle of expansion");
    applyStimulus(abcBlock);
    n = 0;
    while (mGen != 30 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("midrst_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_w_valid", 32'(bus.w_valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    outLog.delete();
    applyStimulus(abcBlock);
    waitDrain(300, "postrst");
    checkOutput("postrst_count", 32'(outLog.size()), 32'd64);
    if (outLog.size() == 64) begin
      checkOutput("postrst_w0", outLog[0], 32'h6162_6380);
      checkOutput("postrst_w16", outLog[16], 32'h6162_6380);
      checkOutput("postrst_w17", outLog[17], 32'h000F_0000);
    end

    $display("[TB] random blocks with random handshakes");
    validPct = 60;
    readyPct = 60;
    for (int b = 0; b < 20; b++) begin
      randomBlock(blk);
      applyStimulus(blk);
    end
    waitDrain(8000, "rand_hs");
    validPct = 100;
    readyPct = 100;

    $display("[TB] 1000 random blocks streamed");
    for (int b = 0; b < 1000; b++) begin
      randomBlock(blk);
      applyStimulus(blk);
    end
    waitDrain(70000, "rand_stream");
    @(negedge clk);
    checkOutput("final_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
